// File: rtl/hs_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : hs_rx_buffer
// Description : Parametrised valid/ready receive buffer. Stores up to DEPTH
//               words in FIFO order and presents them first-word-fall-through
//               on a master valid/ready port, with occupancy, almost-full and
//               an accepted-word counter.
// Revision    : 1.0 - initial release
// ============================================================================
module hs_rx_buffer #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned AFULL_LVL = DEPTH - 1,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [DATA_W-1:0]            s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic [DATA_W-1:0]            m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         almost_full,
  output logic [CNT_W-1:0]             xfer_cnt
);

  localparam int unsigned c_ptr_w = $clog2(DEPTH);
  localparam int unsigned c_lvl_w = $clog2(DEPTH + 1);

  // Storage and pointer state
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [DATA_W-1:0]  mem_d [DEPTH];
  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_lvl_w-1:0] level_q, level_d;
  logic               s_ready_q, s_ready_d;
  logic               afull_q, afull_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Handshake qualifiers, derived only from registered state plus the
  // partner's valid/ready, so there is no m_ready->s_ready path.
  logic w_push;
  logic w_pop;

  assign m_valid = (level_q != '0);
  assign w_push  = s_valid & s_ready_q;
  assign w_pop   = m_valid & m_ready;

  // Head word is forced to zero when nothing valid is stored so that reset
  // and flush present a clean bus without clearing the storage array.
  assign m_data      = m_valid ? mem_q[rd_ptr_q] : '0;
  assign s_ready     = s_ready_q;
  assign level       = level_q;
  assign almost_full = afull_q;
  assign xfer_cnt    = cnt_q;

  // Next-state computation for pointers, level, flags and counter
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    cnt_d    = cnt_q;

    // An accepted word counts even if a flush discards it in the same cycle.
    if (w_push) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (w_push) begin
        wr_ptr_d = wr_ptr_q + c_ptr_w'(1);
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
      end
      case ({w_push, w_pop})
        2'b10:   level_d = level_q + c_lvl_w'(1);
        2'b01:   level_d = level_q - c_lvl_w'(1);
        default: level_d = level_q;
      endcase
    end

    // Flags are registered from level_d so they track level with no lag.
    s_ready_d = (level_d != c_lvl_w'(DEPTH));
    afull_d   = (32'(level_d) >= AFULL_LVL);
  end

  // Storage write; a word pushed during a flush is dropped
  always_comb begin
    mem_d = mem_q;
    if (w_push && !flush) begin
      mem_d[wr_ptr_q] = s_data;
    end
  end

  // Control state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      s_ready_q <= 1'b1;
      afull_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      s_ready_q <= s_ready_d;
      afull_q   <= afull_d;
      cnt_q     <= cnt_d;
    end
  end

  // Storage array register; contents are don't-care until written
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_hs_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_hs_rx_buffer
// Description : Self-checking bench for hs_rx_buffer (DEPTH=4) with a second
//               instance using a 4-bit accepted-word counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hs_rx_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [15:0] s_data = 16'h0;
  logic        s_valid = 1'b0;
  logic        m_ready = 1'b0;

  logic        s_ready, m_valid, almost_full;
  logic [15:0] m_data;
  logic [2:0]  level;
  logic [31:0] xfer_cnt;

  logic        s_ready4, m_valid4, almost_full4;
  logic [15:0] m_data4;
  logic [2:0]  level4;
  logic [3:0]  xfer_cnt4;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] sb_q[$];
  logic        hold_prev = 1'b0;
  logic [15:0] hold_data = 16'h0;

  always #5 clk = ~clk;

  hs_rx_buffer #(.DATA_W(16), .DEPTH(4), .AFULL_LVL(3), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .level(level), .almost_full(almost_full), .xfer_cnt(xfer_cnt)
  );

  hs_rx_buffer #(.DATA_W(16), .DEPTH(4), .AFULL_LVL(3), .CNT_W(4)) u_dut_c4 (
    .clk(clk), .rst(rst), .flush(flush),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready4),
    .m_data(m_data4), .m_valid(m_valid4), .m_ready(m_ready),
    .level(level4), .almost_full(almost_full4), .xfer_cnt(xfer_cnt4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: evaluates the handshake that the next rising edge will see.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      hold_prev = 1'b0;
    end else begin
      chk("sb_level", 32'(level), 32'(sb_q.size()));
      if (hold_prev) begin
        chk("stall_valid", 32'(m_valid), 32'd1);
        chk("stall_data", 32'(m_data), 32'(hold_data));
      end
      if (flush) begin
        sb_q.delete();
      end else begin
        if (m_valid && m_ready) begin
          if (sb_q.size() == 0) begin
            chk("sb_pop_empty", 32'(m_data), 32'hFFFF_FFFF);
          end else begin
            chk("sb_data", 32'(m_data), 32'(sb_q.pop_front()));
          end
        end
        if (s_valid && s_ready) sb_q.push_back(s_data);
      end
      hold_prev = m_valid && !m_ready && !flush;
      hold_data = m_data;
    end
  end

  typedef struct {
    logic        rst;
    logic        flush;
    logic        sv;
    logic [15:0] sd;
    logic        mr;
    logic        e_mv;
    logic [15:0] e_md;
    logic [2:0]  e_lvl;
    logic        e_sr;
    logic        e_af;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[21];

  initial begin
    logic acc;
    //           rst   flush sv    sd        mr    mv    md        lvl   sr    af    cnt
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 32'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 16'h1111, 1'b0, 1'b1, 16'h1111, 3'd1, 1'b1, 1'b0, 32'd1};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 32'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 16'h00A0, 1'b0, 1'b1, 16'h00A0, 3'd1, 1'b1, 1'b0, 32'd1};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 16'h00A1, 1'b0, 1'b1, 16'h00A0, 3'd2, 1'b1, 1'b0, 32'd2};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 16'h00A2, 1'b0, 1'b1, 16'h00A0, 3'd3, 1'b1, 1'b1, 32'd3};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 16'h00A3, 1'b0, 1'b1, 16'h00A0, 3'd4, 1'b0, 1'b1, 32'd4};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 16'h00A4, 1'b0, 1'b1, 16'h00A0, 3'd4, 1'b0, 1'b1, 32'd4};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 16'h00A4, 1'b1, 1'b1, 16'h00A1, 3'd3, 1'b1, 1'b1, 32'd4};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 16'h00A4, 1'b0, 1'b1, 16'h00A1, 3'd4, 1'b0, 1'b1, 32'd5};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h00A2, 3'd3, 1'b1, 1'b1, 32'd5};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h00A3, 3'd2, 1'b1, 1'b0, 32'd5};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 16'h00B0, 1'b0, 1'b1, 16'h00A3, 3'd3, 1'b1, 1'b1, 32'd6};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 16'h00B1, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 32'd7};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b1, 16'hBEEF, 3'd1, 1'b1, 1'b0, 32'd8};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 16'h1234, 1'b1, 1'b1, 16'h1234, 3'd1, 1'b1, 1'b0, 32'd9};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 32'd9};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 16'h00C0, 1'b0, 1'b1, 16'h00C0, 3'd1, 1'b1, 1'b0, 32'd10};
    vecs[18] = '{1'b0, 1'b0, 1'b1, 16'h00C1, 1'b0, 1'b1, 16'h00C0, 3'd2, 1'b1, 1'b0, 32'd11};
    vecs[19] = '{1'b1, 1'b0, 1'b1, 16'h00C2, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 32'd0};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 32'd0};

    // Directed vectors: reset, fill/full, flush, mid-operation reset, empty pop
    for (int i = 0; i < 21; i++) begin
      rst     = vecs[i].rst;
      flush   = vecs[i].flush;
      s_valid = vecs[i].sv;
      s_data  = vecs[i].sd;
      m_ready = vecs[i].mr;
      tick();
      chk($sformatf("v%0d_m_valid", i), 32'(m_valid), 32'(vecs[i].e_mv));
      chk($sformatf("v%0d_m_data", i), 32'(m_data), 32'(vecs[i].e_md));
      chk($sformatf("v%0d_level", i), 32'(level), 32'(vecs[i].e_lvl));
      chk($sformatf("v%0d_s_ready", i), 32'(s_ready), 32'(vecs[i].e_sr));
      chk($sformatf("v%0d_almost_full", i), 32'(almost_full), 32'(vecs[i].e_af));
      chk($sformatf("v%0d_xfer_cnt", i), xfer_cnt, vecs[i].e_cnt);
    end

    // Streaming: continuous push and pop for 20 cycles
    rst = 1'b1; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    tick();
    rst = 1'b0;
    s_valid = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_data = 16'h0100 + 16'(i);
      tick();
    end
    s_valid = 1'b0;
    chk("stream_level", 32'(level), 32'd1);
    chk("stream_cnt", xfer_cnt, 32'd20);
    chk("stream_last", 32'(m_data), 32'h0113);
    tick();
    chk("stream_drained", 32'(level), 32'd0);

    // Random stalls with a held source word until accepted
    rst = 1'b1; m_ready = 1'b0;
    tick();
    rst = 1'b0;
    s_data = 16'($urandom);
    for (int i = 0; i < 1000; i++) begin
      s_valid = 1'($urandom_range(0, 1));
      m_ready = 1'($urandom_range(0, 1));
      acc = s_valid && s_ready;
      tick();
      if (acc) s_data = 16'($urandom);
    end
    s_valid = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("rand_drain_level", 32'(level), 32'd0);
    chk("rand_sb_empty", 32'(sb_q.size()), 32'd0);

    // Narrow counter wrap: 17 accepted words on a 4-bit counter
    rst = 1'b1; s_valid = 1'b0;
    tick();
    rst = 1'b0;
    s_valid = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      s_data = 16'h0200 + 16'(i);
      tick();
    end
    s_valid = 1'b0;
    chk("cnt4_wrap", 32'(xfer_cnt4), 32'd1);
    chk("cnt32_17", xfer_cnt, 32'd17);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
